// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: synchronises and de-glitches the raw PS/2 lines,
// decodes 11-bit frames and assembles 3-byte mouse packets.
// mouseInfo = {packet counter, Y delta, X delta, status}.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames with bad (even)
// parity are rejected; otherwise the parity bit is captured but ignored.
module ps2_mouse_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] mouseInfo,
    output logic        pkt_valid,
    output logic        frame_err
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TO_MAX    = TCW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } frame_state_t;

    logic           clk_meta;
    logic           clk_sync;
    logic           data_meta;
    logic           data_sync;

    logic [FCW-1:0] filt_cnt;
    logic           filt_level;
    logic           filt_flip;
    logic           filt_fall;

    logic [TCW-1:0] to_cnt;
    logic           to_expired;

    frame_state_t   state;
    logic [3:0]     bit_cnt;
    logic [9:0]     shift_reg;
    logic           frame_ok;

    logic [1:0]     byte_idx;
    logic [7:0]     byte0;
    logic [7:0]     byte1;
    logic           pkt_load;

    // Two-flop synchronisers for both raw lines; idle PS/2 lines are high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // The filtered level flips on the FILTER_LEN-th consecutive sample that
    // disagrees with it; any agreeing sample restarts the run.
    assign filt_flip = (clk_sync != filt_level) && (filt_cnt == FILT_LAST);
    assign filt_fall = filt_flip && filt_level;

    // Glitch filter on the synchronised PS/2 clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_cnt   <= '0;
            filt_level <= 1'b1;
        end else if (clk_sync == filt_level) begin
            filt_cnt   <= '0;
        end else if (filt_flip) begin
            filt_cnt   <= '0;
            filt_level <= clk_sync;
        end else begin
            filt_cnt   <= filt_cnt + FCW'(1);
        end
    end

    // Idle counter: cleared by every filtered edge, saturates at TIMEOUT_CYC
    // so an expiry is only acted on once per quiet period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (filt_flip) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + TCW'(1);
        end
    end

    assign to_expired = (to_cnt == TO_MAX) && !filt_flip;

    // After ten shifts shift_reg holds {stop, parity, data[7:0]}.
`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = shift_reg[9] && (^shift_reg[8:0]);
`else
    assign frame_ok = shift_reg[9];
`endif

    // Frame FSM, packet assembler and timeout handling share one register
    // block so that frame_err and pkt_valid each have a single driver and
    // their mutual exclusion is decided in one place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            byte_idx  <= '0;
            byte0     <= '0;
            byte1     <= '0;
            pkt_load  <= 1'b0;
            mouseInfo <= '0;
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
            pkt_load  <= 1'b0;

            // Third byte was accepted last cycle; it still sits in shift_reg
            // because shifting only happens in SHIFT.
            if (pkt_load) begin
                mouseInfo <= {mouseInfo[31:24] + 8'd1, shift_reg[7:0], byte1, byte0};
                pkt_valid <= 1'b1;
                byte_idx  <= '0;
            end

            case (state)
                IDLE: begin
                    if (filt_fall && !data_sync) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end

                SHIFT: begin
                    if (filt_fall) begin
                        shift_reg <= {data_sync, shift_reg[9:1]};
                        if (bit_cnt == 4'd9) begin
                            state <= CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end

                CHECK: begin
                    state <= IDLE;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                        byte_idx  <= '0;
                    end else if ((byte_idx == 2'd0) && !shift_reg[3]) begin
                        frame_err <= 1'b1;
                    end else begin
                        case (byte_idx)
                            2'd0: begin
                                byte0    <= shift_reg[7:0];
                                byte_idx <= 2'd1;
                            end
                            2'd1: begin
                                byte1    <= shift_reg[7:0];
                                byte_idx <= 2'd2;
                            end
                            default: begin
                                pkt_load <= 1'b1;
                            end
                        endcase
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Timeout is deferred while CHECK or a packet load is in flight;
            // the counter stays saturated so it is honoured right after.
            if (to_expired && (state != CHECK) && !pkt_load &&
                ((state != IDLE) || (byte_idx != 2'd0))) begin
                state     <= IDLE;
                byte_idx  <= '0;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Self-checking bench for ps2_mouse_rx: directed scenarios plus randomized
// frames, compared with a byte-queue reference model of the packet rules.
module tb_ps2_mouse_rx;

    localparam int FILTER_LEN  = 2;
    localparam int TIMEOUT_CYC = 300;
    localparam int HALF_BIT    = 3;

    logic        clk;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] mouseInfo;
    logic        pkt_valid;
    logic        frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int pkt_seen = 0;
    int err_seen = 0;

    byte unsigned model_q[$];
    int           exp_pkt = 0;
    int           exp_err = 0;
    logic [31:0]  exp_info = '0;

    ps2_mouse_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .mouseInfo(mouseInfo),
        .pkt_valid(pkt_valid),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count output pulses and require pkt_valid and frame_err never overlap.
    always @(negedge clk) begin
        if (pkt_valid) pkt_seen++;
        if (frame_err) err_seen++;
        if (pkt_valid || frame_err) begin
            n_assert++;
            assert (!(pkt_valid && frame_err)) else begin
                n_fail++;
                $error("FAIL overlap: pkt_valid=%0b frame_err=%0b required not both", pkt_valid, frame_err);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/info"}, mouseInfo, exp_info);
        checkOutput({tag, "/pkts"}, 32'(pkt_seen), 32'(exp_pkt));
        checkOutput({tag, "/errs"}, 32'(err_seen), 32'(exp_err));
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    // Reference model: one received frame under the byte/packet rules.
    task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
        bit good;
        good = s;
`ifdef PS2_PARITY_CHECK_EN
        good = good && (($countones({d, p}) % 2) == 1);
`endif
        if (!good) begin
            exp_err++;
            model_q.delete();
        end else if (model_q.size() == 0 && !d[3]) begin
            exp_err++;
        end else begin
            model_q.push_back(d);
            if (model_q.size() == 3) begin
                exp_info = {exp_info[31:24] + 8'd1, model_q[2], model_q[1], model_q[0]};
                exp_pkt++;
                model_q.delete();
            end
        end
    endtask

    task automatic model_timeout(input bit partial_frame);
        if (partial_frame || model_q.size() != 0) begin
            exp_err++;
            model_q.delete();
        end
    endtask

    task automatic glitch();
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Drive one bit: data set while the clock is high, then clock low.
    task automatic drive_bit(input logic b, input bit with_glitch);
        ps2_data = b;
        ps2_clk  = 1'b1;
        repeat (HALF_BIT) @(negedge clk);
        if (with_glitch) begin
            glitch();
            repeat (HALF_BIT) @(negedge clk);
        end
        ps2_clk = 1'b0;
        repeat (HALF_BIT) @(negedge clk);
    endtask

    task automatic line_idle(input int cycles);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s, input bit with_glitch);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) drive_bit(bits[i], with_glitch);
        line_idle(2 * HALF_BIT);
        model_frame(d, p, s);
    endtask

    task automatic send_good(input logic [7:0] d);
        applyStimulus(d, odd_par(d), 1'b1, 1'b0);
    endtask

    task automatic send_partial(input int nbits);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
        line_idle(2);
    endtask

    task automatic do_reset(input bit check_now, input string tag);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        if (check_now) begin
            checkOutput({tag, "/rst_info"}, mouseInfo, 32'h0);
            checkOutput({tag, "/rst_pkt"}, {31'h0, pkt_valid}, 32'h0);
            checkOutput({tag, "/rst_err"}, {31'h0, frame_err}, 32'h0);
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_q.delete();
        exp_info = '0;
    endtask

    initial begin
        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset/info", mouseInfo, 32'h0);
        checkOutput("reset/pkt", {31'h0, pkt_valid}, 32'h0);
        checkOutput("reset/err", {31'h0, frame_err}, 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Basic packet
        send_good(8'h09);
        send_good(8'h05);
        send_good(8'hFE);
        checkAll("basic");
        checkOutput("basic/spec", mouseInfo, 32'h01FE0509);

        // Bad parity byte, then a valid packet
        do_reset(1'b0, "r1");
        applyStimulus(8'h09, 1'b0, 1'b1, 1'b0);
        checkAll("badpar_byte");
        send_good(8'h09);
        send_good(8'h05);
        send_good(8'hFE);
        checkAll("badpar_pkt");

        // Status byte without bit 3, then a valid packet
        do_reset(1'b0, "r2");
        send_good(8'h01);
        checkAll("nobit3");
        send_good(8'h09);
        send_good(8'h05);
        send_good(8'hFE);
        checkAll("nobit3_pkt");
        checkOutput("nobit3/spec", mouseInfo, 32'h01FE0509);

        // Packet timeout, then partial-frame timeout, then a quiet timeout
        do_reset(1'b0, "r3");
        send_good(8'h09);
        send_good(8'h05);
        line_idle(TIMEOUT_CYC + 100);
        model_timeout(1'b0);
        checkAll("pkt_timeout");
        send_partial(4);
        line_idle(TIMEOUT_CYC + 100);
        model_timeout(1'b1);
        checkAll("frame_timeout");
        line_idle(TIMEOUT_CYC + 100);
        model_timeout(1'b0);
        checkAll("idle_timeout");
        send_good(8'h2C);
        send_good(8'h11);
        send_good(8'hF0);
        checkAll("after_timeout");

        // Short glitches on the clock line must be ignored
        glitch();
        line_idle(20);
        checkAll("idle_glitch");
        applyStimulus(8'h18, odd_par(8'h18), 1'b1, 1'b1);
        applyStimulus(8'h7F, odd_par(8'h7F), 1'b1, 1'b1);
        applyStimulus(8'h80, odd_par(8'h80), 1'b1, 1'b1);
        checkAll("glitch_pkt");

        // Randomized frames with occasional parity / stop errors
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            logic       p;
            logic       s;
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~odd_par(d) : odd_par(d);
            s = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
            applyStimulus(d, p, s, 1'b0);
            checkAll("random");
        end

        // Counter wrap over 256 packets from reset
        do_reset(1'b0, "r4");
        for (int i = 0; i < 256; i++) begin
            send_good(8'($urandom) | 8'h08);
            send_good(8'($urandom));
            send_good(8'($urandom));
            checkOutput("wrap/info", mouseInfo, exp_info);
        end
        checkOutput("wrap/counter", {24'h0, mouseInfo[31:24]}, 32'h0);
        checkAll("wrap");

        // Asynchronous reset in the middle of a packet
        send_good(8'h09);
        send_partial(3);
        do_reset(1'b1, "midpkt");
        send_good(8'h09);
        send_good(8'h05);
        send_good(8'hFE);
        checkAll("post_reset");
        checkOutput("post_reset/spec", mouseInfo, 32'h01FE0509);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
